// File: rtl/wavegen_axi_lite_master.sv
// AXI4-lite initiator for the wavegen register slave.
// One command in flight; AW/W issued together, B/R collected into a response.
module wavegen_axi_lite_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 6,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                   cmd_wdata,
  input  logic [3:0]                    cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [31:0]                   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          timeout_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [31:0]                   M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [31:0]                   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] C_TMAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR_DATA,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RSP
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_awaddr;
  logic [AW-1:0]   r_araddr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wstrb;
  logic            r_awvalid;
  logic            r_wvalid;
  logic            r_bready;
  logic            r_arvalid;
  logic            r_rready;
  logic            r_aw_done;
  logic            r_w_done;
  logic            r_rsp_valid;
  logic            r_rsp_write;
  logic [31:0]     r_rsp_rdata;
  logic [1:0]      r_rsp_resp;
  logic            r_timeout_err;
  logic [CW-1:0]   r_wd_cnt;

  logic [AW-1:0]   w_addr_al;
  logic            w_aw_fin;
  logic            w_w_fin;
  logic            w_active;
  logic            w_wd_sat;
  logic            w_wd_hit;
  logic [CW-1:0]   w_wd_nxt;

  // Word-align the byte address; the slave decodes 32-bit registers only.
  assign w_addr_al = cmd_addr & ~AW'(3);

  assign w_aw_fin = r_aw_done | (r_awvalid & M_AXI_AWREADY);
  assign w_w_fin  = r_w_done  | (r_wvalid  & M_AXI_WREADY);

  assign w_active = (r_state == S_WR_ADDR_DATA) |
                    (r_state == S_WR_RESP) |
                    (r_state == S_RD_ADDR) |
                    (r_state == S_RD_DATA);

  assign w_wd_sat = (r_wd_cnt == C_TMAX);
  assign w_wd_hit = WD_EN & w_active & ~w_wd_sat &
                    ((r_wd_cnt + 1'b1) == C_TMAX);
  assign w_wd_nxt = (WD_EN & w_active & ~w_wd_sat) ?
                    r_wd_cnt + 1'b1 : r_wd_cnt;

  assign cmd_ready     = (r_state == S_IDLE);
  assign rsp_valid     = r_rsp_valid;
  assign rsp_write     = r_rsp_write;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign timeout_err   = r_timeout_err;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

  // Transaction FSM with registered AXI outputs and per-phase watchdog.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state       <= S_IDLE;
      r_awaddr      <= '0;
      r_araddr      <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_write   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= '0;
      r_timeout_err <= 1'b0;
      r_wd_cnt      <= '0;
    end else begin
      r_wd_cnt <= w_wd_nxt;
      if (w_wd_hit) begin
        r_timeout_err <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_wd_cnt <= '0;
            if (cmd_write) begin
              r_awaddr  <= w_addr_al;
              r_wdata   <= cmd_wdata;
              r_wstrb   <= cmd_wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= S_WR_ADDR_DATA;
            end else begin
              r_araddr  <= w_addr_al;
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end
        end
        S_WR_ADDR_DATA: begin
          if (r_awvalid && M_AXI_AWREADY) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (r_wvalid && M_AXI_WREADY) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_wd_cnt <= '0;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (M_AXI_BVALID && r_bready) begin
            r_rsp_resp  <= M_AXI_BRESP;
            r_rsp_rdata <= '0;
            r_rsp_write <= 1'b1;
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_wd_cnt    <= '0;
            r_state     <= S_RSP;
          end
        end
        S_RD_ADDR: begin
          if (r_arvalid && M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_wd_cnt  <= '0;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (M_AXI_RVALID && r_rready) begin
            r_rsp_rdata <= M_AXI_RDATA;
            r_rsp_resp  <= M_AXI_RRESP;
            r_rsp_write <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_wd_cnt    <= '0;
            r_state     <= S_RSP;
          end
        end
        S_RSP: begin
          if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_wd_cnt    <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wavegen_axi_lite_master.sv
// Directed bench for wavegen_axi_lite_master.
// Table of transactions against a scripted slave, then hand-written corner sequences.
module tb_wavegen_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [5:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout_err;
  logic [5:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [5:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;

  always #5 clk = ~clk;

  wavegen_axi_lite_master #(
    .C_M_AXI_ADDR_WIDTH(6),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .timeout_err(timeout_err),
    .M_AXI_AWADDR(awaddr),
    .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata),
    .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata),
    .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    int          ar_dly;
    int          r_dly;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [5:0]  exp_addr;
    logic [31:0] exp_rdata;
    int          to_cyc;
  } vec_t;

  vec_t tbl[6];

  task automatic run_vec(input int idx, input vec_t v);
    int aw_n, w_n, b_n, ar_n, r_n, rsp_n, bwait, rwait, to_first;
    logic hold_bad, first_ok, cap_wr;
    logic [5:0] cap_addr;
    logic [31:0] cap_wdata, cap_rdata;
    logic [3:0] cap_wstrb;
    logic [1:0] cap_resp;
    logic [19:0] hs, hs_exp;
    bit done;
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; rsp_n = 0;
    bwait = 0; rwait = 0; to_first = 0;
    hold_bad = 1'b0; first_ok = 1'b0; cap_wr = 1'b0;
    cap_addr = '0; cap_wdata = '0; cap_rdata = '0;
    cap_wstrb = '0; cap_resp = '0; done = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_cmd_ready_idle", idx), 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_wstrb = v.wstrb;
    bresp = v.resp;
    rresp = v.resp;
    rdata = v.rdata;
    rsp_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (c == 1)
        first_ok = v.wr ? (awvalid & wvalid & ~arvalid)
                        : (arvalid & ~awvalid & ~wvalid);
      if (timeout_err && to_first == 0) to_first = c;
      if (awvalid) begin
        if (awaddr !== v.exp_addr) hold_bad = 1'b1;
        cap_addr = awaddr;
      end
      if (wvalid) begin
        if (wdata !== v.wdata || wstrb !== v.wstrb) hold_bad = 1'b1;
        cap_wdata = wdata;
        cap_wstrb = wstrb;
      end
      if (arvalid) begin
        if (araddr !== v.exp_addr) hold_bad = 1'b1;
        cap_addr = araddr;
      end
      if (aw_n > 0 && w_n > 0) bwait++;
      if (ar_n > 0) rwait++;
      awready = (c > v.aw_dly);
      wready  = (c > v.w_dly);
      arready = (c > v.ar_dly);
      bvalid  = (b_n == 0) && (bwait > v.b_dly);
      rvalid  = (r_n == 0) && (rwait > v.r_dly);
      if (awvalid && awready) aw_n++;
      if (wvalid && wready) w_n++;
      if (bvalid && bready) b_n++;
      if (arvalid && arready) ar_n++;
      if (rvalid && rready) r_n++;
      if (rsp_valid) begin
        rsp_n++;
        cap_wr = rsp_write;
        cap_rdata = rsp_rdata;
        cap_resp = rsp_resp;
        done = 1'b1;
      end
      @(posedge clk);
    end
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; rvalid = 1'b0;
    hs = {4'(aw_n), 4'(w_n), 4'(b_n), 4'(ar_n), 4'(r_n)};
    hs_exp = v.wr ? 20'h11100 : 20'h00011;
    chk($sformatf("v%0d_issue_next_cycle", idx), 32'(first_ok), 32'd1);
    chk($sformatf("v%0d_rsp_count", idx), 32'(rsp_n), 32'd1);
    chk($sformatf("v%0d_handshakes", idx), 32'(hs), 32'(hs_exp));
    chk($sformatf("v%0d_addr", idx), 32'(cap_addr), 32'(v.exp_addr));
    if (v.wr) begin
      chk($sformatf("v%0d_wdata", idx), cap_wdata, v.wdata);
      chk($sformatf("v%0d_wstrb", idx), 32'(cap_wstrb), 32'(v.wstrb));
    end
    chk($sformatf("v%0d_payload_stable", idx), 32'(hold_bad), 32'd0);
    chk($sformatf("v%0d_rsp_write", idx), 32'(cap_wr), 32'(v.wr));
    chk($sformatf("v%0d_rsp_rdata", idx), cap_rdata, v.exp_rdata);
    chk($sformatf("v%0d_rsp_resp", idx), 32'(cap_resp), 32'(v.resp));
    chk($sformatf("v%0d_timeout_rise", idx), 32'(to_first), 32'(v.to_cyc));
    chk($sformatf("v%0d_timeout_end", idx), 32'(timeout_err),
        32'(v.to_cyc != 0));
    @(negedge clk);
    chk($sformatf("v%0d_back_idle", idx),
        32'({cmd_ready, rsp_valid}), 32'b10);
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    tbl[0] = '{1'b1, 6'h08, 32'h0000C350, 4'hF, 0, 0, 0, 0, 0,
               32'h0, 2'b00, 6'h08, 32'h0, 0};
    tbl[1] = '{1'b1, 6'h14, 32'h7FFF4000, 4'hF, 3, 0, 1, 0, 0,
               32'h0, 2'b00, 6'h14, 32'h0, 0};
    tbl[2] = '{1'b0, 6'h13, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, 2,
               32'h12345678, 2'b00, 6'h10, 32'h12345678, 0};
    tbl[3] = '{1'b1, 6'h1E, 32'hA5A50001, 4'h3, 1, 2, 0, 0, 0,
               32'hCAFEF00D, 2'b10, 6'h1C, 32'h0, 0};
    tbl[4] = '{1'b0, 6'h3F, 32'h0, 4'h0, 0, 0, 0, 2, 0,
               32'hDEADBEEF, 2'b11, 6'h3C, 32'hDEADBEEF, 0};
    tbl[5] = '{1'b1, 6'h20, 32'h00000400, 4'hF, 20, 0, 0, 0, 0,
               32'h0, 2'b00, 6'h20, 32'h0, 9};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_write, rsp_resp}), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_payload", 32'({awaddr, araddr, wstrb}), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_prot", 32'({awprot, arprot}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i, tbl[i]);

    // Response backpressure with a queued command
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h04;
    cmd_wdata = 32'h00000011; cmd_wstrb = 4'hF;
    awready = 1'b1; wready = 1'b1; bresp = 2'b01; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("bp_bready", 32'(bready), 32'd1);
    bvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    chk("bp_rsp_first", 32'({rsp_valid, rsp_write, rsp_resp}), 32'b1101);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h22;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k),
          32'({rsp_valid, rsp_write, rsp_resp, cmd_ready, arvalid}),
          32'b110100);
      chk($sformatf("bp_rdata%0d", k), rsp_rdata, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_after_ready", 32'({cmd_ready, arvalid, rsp_valid}), 32'b100);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_accepted", 32'({cmd_ready, arvalid}), 32'b01);
    chk("bp_araddr", 32'(araddr), 32'h20);
    arready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arready = 1'b0;
    chk("rd_data_rready", 32'({rready, arvalid}), 32'b10);
    chk("timeout_sticky", 32'(timeout_err), 32'd1);

    // Reset while waiting for read data
    rst = 1'b1; rvalid = 1'b1; rdata = 32'h55AA55AA; rresp = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_outputs",
        32'({rready, rsp_valid, cmd_ready, arvalid, timeout_err}),
        32'b00100);
    chk("midrst_rdata", rsp_rdata, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("midrst_quiet%0d", k),
          32'({rsp_valid, rready, cmd_ready}), 32'b001);
    end
    rvalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
